// File: rtl/blk_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : blk_pkg
// Description : Shared types, block type codes and header-word packing
//               helpers for the block builder.
// Revision    : 1.0 - initial release
// ============================================================================
package blk_pkg;

    // Block builder control states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M0    = 3'd1,
        M1    = 3'd2,
        M2    = 3'd3,
        MDATA = 3'd4,
        S1    = 3'd5,
        S2    = 3'd6,
        SDATA = 3'd7
    } blk_state_t;

    localparam logic [2:0] TYPE_MASTER = 3'b110;
    localparam logic [2:0] TYPE_SELF   = 3'b000;

    // Word 0: start marker followed by channel number and block length
    function automatic logic [15:0] pack_w0(input logic [14:0] num_len);
        return {1'b1, num_len};
    endfunction

    // Word 1: block type, parity bit and the 10-bit tag (time high or counter)
    function automatic logic [15:0] pack_w1(input logic [2:0] typ,
                                            input logic       par,
                                            input logic [9:0] n10);
        return {1'b0, typ, par, 1'b0, n10};
    endfunction

endpackage
`default_nettype wire

// File: rtl/blk_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : blk_fifo
// Description : Single-clock output FIFO with transactional write side.
//               Words become visible to the reader only after commit; a
//               rewind drops every word written since the last commit.
// Revision    : 1.0 - initial release
// ============================================================================
module blk_fifo #(
    parameter int FBITS = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [15:0]      wr_data,
    input  logic             commit,
    input  logic             rewind,
    input  logic             give,
    output logic             have,
    output logic [15:0]      dout,
    output logic [FBITS-1:0] free
);

    logic [15:0]      r_mem [0:(1<<FBITS)-1];
    logic [FBITS-1:0] r_waddr;
    logic [FBITS-1:0] r_blkend;
    logic [FBITS-1:0] r_raddr;
    logic [FBITS-1:0] w_waddr_nxt;

    assign w_waddr_nxt = wr_en ? (r_waddr + FBITS'(1)) : r_waddr;
    // Reader only sees data up to the commit point
    assign have        = give & (r_raddr != r_blkend);
    // Free space measured from the commit point, one slot kept as separator
    assign free        = r_raddr - r_blkend - FBITS'(1);

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en && !rewind) begin
            r_mem[r_waddr] <= wr_data;
        end
    end

    // Write, commit and read pointers plus registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr  <= '0;
            r_blkend <= '0;
            r_raddr  <= '0;
            dout     <= '0;
        end else begin
            if (rewind) begin
                r_waddr <= r_blkend;
            end else begin
                r_waddr <= w_waddr_nxt;
            end
            if (commit) begin
                r_blkend <= w_waddr_nxt;
            end
            if (have) begin
                dout    <= r_mem[r_raddr];
                r_raddr <= r_raddr + FBITS'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/blk_builder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : blk_builder
// Description : Per-channel block builder. Keeps a circular prehistory of
//               samples, cuts master- or self-triggered windows into framed
//               blocks and stores them in a commit/rewind output FIFO.
//               Optional macro ZSUP_EN adds zero suppression of self blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module blk_builder
    import blk_pkg::*;
#(
    parameter int ABITS  = 12,
    parameter int CBITS  = 10,
    parameter int FBITS  = 11,
    parameter int CHBITS = 6,
    parameter int WBITS  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHBITS-1:0] num,
    input  logic [15:0]       din,
    input  logic [ABITS-1:0]  ped,
    input  logic              mtrig,
    input  logic [24:0]       gtime,
    input  logic              strig,
    input  logic [9:0]        strig_cnt,
    input  logic [CBITS-1:0]  mwinbeg,
    input  logic [CBITS-1:0]  swinbeg,
    input  logic [WBITS-1:0]  winlen,
    input  logic              zsup,
    input  logic [14:0]       zthr,
    input  logic              give,
    output logic              have,
    output logic [15:0]       dout,
    output logic              missed,
    output logic [FBITS-1:0]  fifo_free
);

    // Circular prehistory buffer
    logic [15:0]      r_cb_mem [0:(1<<CBITS)-1];
    logic [CBITS-1:0] r_cb_waddr;
    logic [CBITS-1:0] r_cb_raddr;
    logic [15:0]      r_cb_rdata;

    blk_state_t       r_state;
    blk_state_t       w_next;
    logic [WBITS-1:0] r_cnt;
    logic             r_par;
    logic [24:0]      r_gtime;
    logic [9:0]       r_strig_cnt;
    logic [ABITS-1:0] r_ped;

    logic             w_wr_en;
    logic [15:0]      w_wr_data;
    logic             w_commit;
    logic             w_rewind;
    logic             w_lat_m;
    logic             w_lat_s;
    logic             w_par_tgl;
    logic             w_len_ok;
    logic             w_fits;
    logic             w_last;
    logic             w_suppress;
    logic [WBITS-1:0] w_len2;
    logic [15:0]      w_w0;
    logic [15:0]      w_data_word;
    logic [CBITS-1:0] w_winbeg;

    assign w_len_ok    = (winlen != '0);
    assign w_fits      = (32'(fifo_free) >= (32'(winlen) + 32'd4));
    assign w_last      = (r_cnt == (winlen - WBITS'(1)));
    assign w_len2      = winlen + WBITS'(2);
    assign w_w0        = pack_w0({num, w_len2});
    assign w_data_word = {1'b0, r_cb_rdata[14:0]};
    assign w_winbeg    = (r_state == M1) ? mwinbeg : swinbeg;

`ifdef ZSUP_EN
    logic        r_zhit;
    logic [15:0] w_abs;
    logic        w_hit_now;

    assign w_abs      = r_cb_rdata[15] ? (16'd0 - r_cb_rdata) : r_cb_rdata;
    assign w_hit_now  = (w_abs >= {1'b0, zthr});
    // Block is dropped when no sample of the window reached the threshold
    assign w_suppress = zsup & ~(r_zhit | w_hit_now);

    // Remember whether any sample of the current self window was large
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zhit <= 1'b0;
        end else if (r_state == SDATA) begin
            r_zhit <= r_zhit | w_hit_now;
        end else begin
            r_zhit <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused   = &{1'b0, zsup, zthr, r_cb_rdata[15]};
    assign w_suppress = 1'b0;
`endif

    // Prehistory write every clock and synchronous read of the window
    always_ff @(posedge clk) begin
        r_cb_mem[r_cb_waddr] <= din;
        r_cb_rdata           <= r_cb_mem[r_cb_raddr];
    end

    // Prehistory pointers; read pointer is placed at window start in M1/S1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cb_waddr <= '0;
            r_cb_raddr <= '0;
        end else begin
            r_cb_waddr <= r_cb_waddr + CBITS'(1);
            if ((r_state == M1) || ((r_state == S1) && !mtrig)) begin
                r_cb_raddr <= r_cb_waddr - w_winbeg;
            end else begin
                r_cb_raddr <= r_cb_raddr + CBITS'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and FIFO write control
    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_wr_data = '0;
        w_commit  = 1'b0;
        w_rewind  = 1'b0;
        w_lat_m   = 1'b0;
        w_lat_s   = 1'b0;
        w_par_tgl = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_len_ok && w_fits) begin
                    if (mtrig) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_w0;
                        w_lat_m   = 1'b1;
                        w_next    = M1;
                    end else if (strig) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_w0;
                        w_lat_s   = 1'b1;
                        w_next    = S1;
                    end
                end
            end
            M0: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_w0;
                w_next    = M1;
            end
            M1: begin
                w_wr_en   = 1'b1;
                w_wr_data = pack_w1(TYPE_MASTER, r_par, r_gtime[24:15]);
                w_next    = M2;
            end
            M2: begin
                w_wr_en   = 1'b1;
                w_wr_data = {1'b0, r_gtime[14:0]};
                w_next    = MDATA;
            end
            MDATA: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_data_word;
                if (w_last) begin
                    w_commit  = 1'b1;
                    w_par_tgl = 1'b1;
                    w_next    = IDLE;
                end
            end
            S1, S2, SDATA: begin
                if (mtrig) begin
                    // Master trigger pre-empts the self block in progress
                    w_rewind = 1'b1;
                    w_lat_m  = 1'b1;
                    w_next   = M0;
                end else if (r_state == S1) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = pack_w1(TYPE_SELF, r_par, r_strig_cnt);
                    w_next    = S2;
                end else if (r_state == S2) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = {{(16-ABITS){1'b0}}, r_ped};
                    w_next    = SDATA;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_data_word;
                    if (w_last) begin
                        if (w_suppress) begin
                            w_rewind = 1'b1;
                        end else begin
                            w_commit  = 1'b1;
                            w_par_tgl = 1'b1;
                        end
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Data counter, parity, latched trigger context and missed pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_gtime     <= '0;
            r_strig_cnt <= '0;
            r_ped       <= '0;
            missed      <= 1'b0;
        end else begin
            if ((r_state == MDATA) || (r_state == SDATA)) begin
                r_cnt <= r_cnt + WBITS'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_par_tgl) begin
                r_par <= ~r_par;
            end
            if (w_lat_m) begin
                r_gtime <= gtime;
            end
            if (w_lat_s) begin
                r_strig_cnt <= strig_cnt;
                r_ped       <= ped;
            end
            missed <= mtrig & w_len_ok &
                      ((r_state inside {M0, M1, M2, MDATA}) ||
                       ((r_state == IDLE) && !w_fits));
        end
    end

    blk_fifo #(
        .FBITS (FBITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .commit  (w_commit),
        .rewind  (w_rewind),
        .give    (give),
        .have    (have),
        .dout    (dout),
        .free    (fifo_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_blk_builder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_blk_builder
// Description : Scoreboard bench for blk_builder with directed trigger
//               scenarios (master, self, abort, overflow, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blk_builder;

    localparam int ABITS  = 12;
    localparam int CBITS  = 10;
    localparam int FBITS  = 6;
    localparam int CHBITS = 6;
    localparam int WBITS  = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CHBITS-1:0] num;
    logic [15:0]       din;
    logic [ABITS-1:0]  ped;
    logic              mtrig;
    logic [24:0]       gtime;
    logic              strig;
    logic [9:0]        strig_cnt;
    logic [CBITS-1:0]  mwinbeg;
    logic [CBITS-1:0]  swinbeg;
    logic [WBITS-1:0]  winlen;
    logic              zsup;
    logic [14:0]       zthr;
    logic              give;
    logic              have;
    logic [15:0]       dout;
    logic              missed;
    logic [FBITS-1:0]  fifo_free;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mode = 0;
    int          miss_seen = 0;
    int          t0;
    logic [15:0] zval = 16'd0;
    logic        exp_par = 1'b0;
    logic [15:0] sb [$];
    logic        took;
    logic [15:0] exp_word;

    always #5 clk = ~clk;

    blk_builder #(
        .ABITS  (ABITS),
        .CBITS  (CBITS),
        .FBITS  (FBITS),
        .CHBITS (CHBITS),
        .WBITS  (WBITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .num       (num),
        .din       (din),
        .ped       (ped),
        .mtrig     (mtrig),
        .gtime     (gtime),
        .strig     (strig),
        .strig_cnt (strig_cnt),
        .mwinbeg   (mwinbeg),
        .swinbeg   (swinbeg),
        .winlen    (winlen),
        .zsup      (zsup),
        .zthr      (zthr),
        .give      (give),
        .have      (have),
        .dout      (dout),
        .missed    (missed),
        .fifo_free (fifo_free)
    );

    // Sample presented at bench cycle c
    function automatic logic [15:0] samp(input int c);
        if (mode == 0) return 16'(c * 7 + 3);
        return zval;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        din = samp(cyc);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected master block whose word 0 is written in cycle t
    task automatic push_master(input int t);
        logic [15:0] d;
        sb.push_back({1'b1, num, winlen + 9'd2});
        sb.push_back({1'b0, 3'b110, exp_par, 1'b0, gtime[24:15]});
        sb.push_back({1'b0, gtime[14:0]});
        for (int k = 0; k < int'(winlen); k++) begin
            d = samp(t + 1 - int'(mwinbeg) + k);
            sb.push_back({1'b0, d[14:0]});
        end
        exp_par = ~exp_par;
    endtask

    // Expected self block whose word 0 is written in cycle t
    task automatic push_self(input int t);
        logic [15:0] d;
        sb.push_back({1'b1, num, winlen + 9'd2});
        sb.push_back({1'b0, 3'b000, exp_par, 1'b0, strig_cnt});
        sb.push_back({4'b0000, ped});
        for (int k = 0; k < int'(winlen); k++) begin
            d = samp(t + 1 - int'(swinbeg) + k);
            sb.push_back({1'b0, d[14:0]});
        end
        exp_par = ~exp_par;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words left, required 0", sb.size());
        end
    endtask

    // Monitor: every accepted read is compared against the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            took = have && rst_n;
            if (missed) miss_seen++;
            @(negedge clk);
            if (took) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %04h required none", dout);
                end else begin
                    exp_word = sb.pop_front();
                    if (dout !== exp_word) begin
                        errors++;
                        $display("FAIL fifo_word: got %04h required %04h", dout, exp_word);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        num       = 6'h2A;
        din       = 16'd0;
        ped       = 12'hABC;
        mtrig     = 1'b0;
        gtime     = 25'h1ABCDEF;
        strig     = 1'b0;
        strig_cnt = 10'h155;
        mwinbeg   = 10'd2;
        swinbeg   = 10'd3;
        winlen    = 9'd4;
        zsup      = 1'b0;
        zthr      = 15'd100;
        give      = 1'b1;

        // Reset values
        repeat (3) tick();
        chk("rst_have", have, 0);
        chk("rst_dout", dout, 0);
        chk("rst_missed", missed, 0);
        chk("rst_free", fifo_free, 63);
        rst_n = 1'b1;
        repeat (20) tick();

        // Basic master block and commit latency
        tick(); t0 = cyc; mtrig = 1'b1; push_master(t0);
        tick(); mtrig = 1'b0;
        while (cyc < t0 + 6) tick();
        chk("have_before_commit", have, 0);
        chk("free_before_commit", fifo_free, 63);
        tick();
        chk("have_at_commit", have, 1);
        chk("free_after_commit", fifo_free, 56);
        repeat (15) tick();

        // Master trigger while busy in M2 is reported as missed
        tick(); t0 = cyc; mtrig = 1'b1; push_master(t0);
        tick(); mtrig = 1'b0;
        tick(); mtrig = 1'b1;
        tick(); mtrig = 1'b0;
        chk("missed_busy", missed, 1);
        tick();
        chk("missed_pulse_end", missed, 0);
        repeat (15) tick();

        // winlen = 0: no block, no missed
        winlen = 9'd0;
        tick(); mtrig = 1'b1;
        tick(); mtrig = 1'b0;
        chk("missed_winlen0", missed, 0);
        repeat (5) tick();
        chk("free_winlen0", fifo_free, 63);
        winlen = 9'd4;

        // Self block aborted by master at SDATA word 2
        tick(); t0 = cyc; strig = 1'b1;
        tick(); strig = 1'b0;
        tick(); tick(); tick();
        mtrig = 1'b1; push_master(t0 + 5);
        tick(); mtrig = 1'b0;
        chk("missed_abort", missed, 0);
        repeat (20) tick();

        // Coincident master and self triggers
        tick(); t0 = cyc; mtrig = 1'b1; strig = 1'b1; push_master(t0);
        tick(); mtrig = 1'b0; strig = 1'b0;
        chk("missed_coincide", missed, 0);
        repeat (20) tick();

        // Plain self block
        tick(); t0 = cyc; strig = 1'b1; push_self(t0);
        tick(); strig = 1'b0;
        repeat (20) tick();

        // Zero suppression: small window, then large window
        mode = 1; zval = -16'sd50; zsup = 1'b1;
        repeat (10) tick();
        tick(); t0 = cyc; strig = 1'b1;
`ifndef ZSUP_EN
        push_self(t0);
`endif
        tick(); strig = 1'b0;
        repeat (20) tick();
        chk("free_after_small", fifo_free, 63);
        zval = -16'sd150;
        repeat (10) tick();
        tick(); t0 = cyc; strig = 1'b1; push_self(t0);
        tick(); strig = 1'b0;
        repeat (20) tick();
        zsup = 1'b0; mode = 0;
        repeat (10) tick();
        tick(); t0 = cyc; mtrig = 1'b1; push_master(t0);
        tick(); mtrig = 1'b0;
        repeat (20) tick();

        // Fill FIFO without reading; third master is lost
        give = 1'b0; winlen = 9'd20;
        tick(); t0 = cyc; mtrig = 1'b1; push_master(t0);
        tick(); mtrig = 1'b0;
        repeat (30) tick();
        chk("free_fill1", fifo_free, 40);
        tick(); t0 = cyc; mtrig = 1'b1; push_master(t0);
        tick(); mtrig = 1'b0;
        repeat (30) tick();
        chk("free_fill2", fifo_free, 17);
        tick(); mtrig = 1'b1;
        tick(); mtrig = 1'b0;
        chk("missed_full", missed, 1);
        repeat (5) tick();
        chk("free_full_nowrite", fifo_free, 17);
        chk("have_give0", have, 0);
        give = 1'b1;
        wait_drain();
        chk("free_drained", fifo_free, 63);

        // One more block so parity is nonzero before reset
        winlen = 9'd4;
        tick(); t0 = cyc; mtrig = 1'b1; push_master(t0);
        tick(); mtrig = 1'b0;
        wait_drain();

        // Reset in the middle of MDATA
        tick(); mtrig = 1'b1;
        tick(); mtrig = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_have", have, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_missed", missed, 0);
        chk("midrst_free", fifo_free, 63);
        tick(); tick();
        rst_n = 1'b1;
        exp_par = 1'b0;
        repeat (10) tick();
        tick(); t0 = cyc; mtrig = 1'b1; push_master(t0);
        tick(); mtrig = 1'b0;
        wait_drain();

        chk("missed_total", miss_seen, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
